// File: rtl/lf_prefix_adder_pipe.sv
// Three-stage pipelined Ladner-Fischer adder with per-beat exact/approximate
// (lower-part-OR) mode, valid/ready flow control and saturating error statistics.
module lf_prefix_adder_pipe #(
    parameter int unsigned W  = 16,
    parameter int unsigned K  = 4,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    input  logic          in_approx,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W:0]    out_sum,
    output logic          out_approx,
    output logic          out_err,
    input  logic          clr_cnt,
    output logic [CW-1:0] txn_cnt,
    output logic [CW-1:0] err_cnt
);

    localparam int unsigned LV  = $clog2(W);
    localparam int unsigned KM1 = (K > 0) ? K - 1 : 0;

    // Group generate of bits [i:0]. At level l every bit with bit l of its index
    // set merges with the top bit of the preceding aligned 2^l block, which is
    // never itself updated at that level, so in-place evaluation is safe.
    function automatic logic [W-1:0] lf_group(input logic [W-1:0] g_in,
                                              input logic [W-1:0] p_in);
        logic [W-1:0] gg;
        logic [W-1:0] pp;
        int unsigned  m;
        gg = g_in;
        pp = p_in;
        for (int unsigned l = 0; l < LV; l++) begin
            for (int unsigned i = 0; i < W; i++) begin
                if (((i >> l) & 1) == 1) begin
                    m     = ((i >> l) << l) - 1;
                    gg[i] = gg[i] | (pp[i] & gg[m]);
                    pp[i] = pp[i] & pp[m];
                end
            end
        end
        return gg;
    endfunction

    // Stage state
    logic         v1, v2;
    logic [W-1:0] a1, b1, g1, p1;
    logic         ap1;
    logic [W-1:0] p2, o2;
    logic [W:0]   cx2, ca2;
    logic         ap2;

    logic ld1, ld2, ld3;

    assign ld3      = !out_valid || out_ready;
    assign ld2      = !v2 || ld3;
    assign ld1      = !v1 || ld2;
    assign in_ready = ld1;

    // Carry computation feeding stage 2
    logic [W-1:0] gx, gm, pm, ga;
    logic         ck;
    logic [W:0]   cx_n, ca_n;

    always_comb begin
        ck = (K > 0) ? g1[KM1] : 1'b0;
        gx = lf_group(g1, p1);
        gm = '0;
        pm = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (i >= K) begin
                gm[i] = g1[i];
                pm[i] = p1[i];
            end
        end
        // Speculated carry-in folded into the lowest upper-part generate.
        gm[K] = g1[K] | (p1[K] & ck);
        ga    = lf_group(gm, pm);
        cx_n  = '0;
        ca_n  = '0;
        ca_n[K] = ck;
        for (int unsigned i = 0; i < W; i++) begin
            cx_n[i+1] = gx[i];
            if (i >= K) ca_n[i+1] = ga[i];
        end
    end

    // Sum selection feeding stage 3
    logic [W:0] ex_sum, apx_sum, sel_sum;

    always_comb begin
        ex_sum     = {cx2[W], p2 ^ cx2[W-1:0]};
        apx_sum    = '0;
        apx_sum[W] = ca2[W];
        for (int unsigned i = 0; i < W; i++) begin
            apx_sum[i] = (i < K) ? o2[i] : (p2[i] ^ ca2[i]);
        end
        sel_sum = ap2 ? apx_sum : ex_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1  <= 1'b0;
            a1  <= '0;
            b1  <= '0;
            g1  <= '0;
            p1  <= '0;
            ap1 <= 1'b0;
        end else if (ld1) begin
            v1 <= in_valid;
            if (in_valid) begin
                a1  <= in_a;
                b1  <= in_b;
                g1  <= in_a & in_b;
                p1  <= in_a ^ in_b;
                ap1 <= in_approx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2  <= 1'b0;
            p2  <= '0;
            o2  <= '0;
            cx2 <= '0;
            ca2 <= '0;
            ap2 <= 1'b0;
        end else if (ld2) begin
            v2 <= v1;
            if (v1) begin
                p2  <= p1;
                o2  <= a1 | b1;
                cx2 <= cx_n;
                ca2 <= ca_n;
                ap2 <= ap1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_sum    <= '0;
            out_approx <= 1'b0;
            out_err    <= 1'b0;
        end else if (ld3) begin
            out_valid <= v2;
            if (v2) begin
                out_sum    <= sel_sum;
                out_approx <= ap2;
                out_err    <= (sel_sum != ex_sum);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_cnt <= '0;
            err_cnt <= '0;
        end else if (clr_cnt) begin
            txn_cnt <= '0;
            err_cnt <= '0;
        end else if (out_valid && out_ready) begin
            if (txn_cnt != '1) txn_cnt <= txn_cnt + CW'(1);
            if (out_err && err_cnt != '1) err_cnt <= err_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_lf_prefix_adder_pipe.sv
// Directed and randomised checks of lf_prefix_adder_pipe (W=16, K=4) against a
// behavioural reference; a CW=4 instance shares the stimulus for saturation.
module tb_lf_prefix_adder_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_approx;
    logic [15:0] in_a, in_b;
    logic        out_valid, out_ready, out_approx, out_err;
    logic [16:0] out_sum;
    logic        clr_cnt;
    logic [15:0] txn_cnt, err_cnt;

    logic        d4_in_ready, d4_out_valid, d4_out_approx, d4_out_err;
    logic [16:0] d4_out_sum;
    logic [3:0]  d4_txn, d4_err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lf_prefix_adder_pipe #(.W(16), .K(4), .CW(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_approx(in_approx),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_approx(out_approx), .out_err(out_err), .clr_cnt(clr_cnt),
        .txn_cnt(txn_cnt), .err_cnt(err_cnt)
    );

    lf_prefix_adder_pipe #(.W(16), .K(4), .CW(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d4_in_ready),
        .in_a(in_a), .in_b(in_b), .in_approx(in_approx),
        .out_valid(d4_out_valid), .out_ready(out_ready), .out_sum(d4_out_sum),
        .out_approx(d4_out_approx), .out_err(d4_out_err), .clr_cnt(clr_cnt),
        .txn_cnt(d4_txn), .err_cnt(d4_err)
    );

    // Reference: exact add, or OR on the low 4 bits plus upper add with carry-in a[3]&b[3].
    function automatic logic [16:0] ref_sum(input logic [15:0] a, input logic [15:0] b,
                                            input logic ap);
        logic [12:0] hi;
        if (!ap) return {1'b0, a} + {1'b0, b};
        hi = {1'b0, a[15:4]} + {1'b0, b[15:4]} + {12'b0, a[3] & b[3]};
        return {hi, a[3:0] | b[3:0]};
    endfunction

    function automatic logic [18:0] ref_beat(input logic [15:0] a, input logic [15:0] b,
                                             input logic ap);
        logic [16:0] s;
        s = ref_sum(a, b, ap);
        return {ap, s != ref_sum(a, b, 1'b0), s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
    endtask

    task automatic send_beat(input logic [15:0] a, input logic [15:0] b, input logic ap,
                             output int lat, output logic [16:0] s, output logic e,
                             output logic m);
        int guard = 0;
        in_a = a; in_b = b; in_approx = ap; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        s = out_sum; e = out_err; m = out_approx;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
        in_a = '0; in_b = '0; in_approx = 1'b0;
        #12;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_in_rst got %0b want 0", out_valid); end
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({in_ready, out_valid, out_sum, out_approx, out_err} !== {1'b1, 1'b0, 17'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs got rdy=%0b vld=%0b sum=%h apx=%0b err=%0b want 1 0 0 0 0",
                     in_ready, out_valid, out_sum, out_approx, out_err);
        end
        n_cmp++;
        if (txn_cnt !== 16'd0 || err_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_counters got txn=%0d err=%0d want 0 0", txn_cnt, err_cnt);
        end
    endtask

    task automatic test_exact();
        int lat; logic [16:0] s; logic e, m; logic [15:0] t0, e0;
        t0 = txn_cnt; e0 = err_cnt;
        send_beat(16'hFFFF, 16'h0001, 1'b0, lat, s, e, m);
        n_cmp++;
        if (lat !== 3) begin n_fail++; $display("FAIL exact_latency got %0d want 3", lat); end
        n_cmp++;
        if ({s, e, m} !== {17'h10000, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL exact_ffff_1 got sum=%h err=%0b apx=%0b want 10000 0 0", s, e, m);
        end
        tick();
        n_cmp++;
        if (txn_cnt !== t0 + 16'd1 || err_cnt !== e0) begin
            n_fail++; $display("FAIL exact_counters got txn=%0d err=%0d want %0d %0d", txn_cnt, err_cnt, t0 + 1, e0);
        end
    endtask

    task automatic test_approx();
        int lat; logic [16:0] s; logic e, m; logic [15:0] e0;
        e0 = err_cnt;
        send_beat(16'h000F, 16'h0001, 1'b1, lat, s, e, m);
        n_cmp++;
        if ({s, e, m} !== {17'h0000F, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL approx_f_1 got sum=%h err=%0b apx=%0b want 0000f 1 1", s, e, m);
        end
        tick();
        n_cmp++;
        if (err_cnt !== e0 + 16'd1) begin n_fail++; $display("FAIL approx_errcnt got %0d want %0d", err_cnt, e0 + 1); end
        send_beat(16'h1234, 16'h4321, 1'b1, lat, s, e, m);
        n_cmp++;
        if ({s, e, m} !== {17'h05555, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL approx_1234_4321 got sum=%h err=%0b apx=%0b want 05555 0 1", s, e, m);
        end
        tick();
        send_beat(16'hFFFF, 16'hFFFF, 1'b1, lat, s, e, m);
        n_cmp++;
        if ({s, e, m} !== {17'h1FFFF, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL approx_ffff_ffff got sum=%h err=%0b apx=%0b want 1ffff 1 1", s, e, m);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [18:0] q[$]; logic [18:0] ex;
        int sent = 0, recv = 0, cyc = 0;
        logic acc = 1'b0, stall = 1'b0;
        logic [16:0] hs; logic he, ha;
        in_valid = 1'b0; out_ready = 1'b0;
        pulse_clr();
        n_cmp++;
        if (txn_cnt !== 16'd0 || d4_txn !== 4'd0) begin
            n_fail++; $display("FAIL clr_idle got txn=%0d txn4=%0d want 0 0", txn_cnt, d4_txn);
        end
        while (recv < 100 && cyc < 3000) begin
            if (!in_valid || acc) begin
                if (sent < 100) begin
                    in_a = 16'($urandom); in_b = 16'($urandom);
                    in_approx = 1'($urandom_range(0, 1));
                    in_valid = ($urandom_range(0, 3) != 0);
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (stall) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_sum !== hs || out_err !== he || out_approx !== ha) begin
                    n_fail++;
                    $display("FAIL stall_hold got vld=%0b sum=%h err=%0b apx=%0b want 1 %h %0b %0b",
                             out_valid, out_sum, out_err, out_approx, hs, he, ha);
                end
            end
            acc = in_valid && in_ready;
            if (acc) begin
                q.push_back(ref_beat(in_a, in_b, in_approx));
                sent++;
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL stream_extra_beat got sum=%h want none", out_sum);
                end else begin
                    ex = q.pop_front();
                    if ({out_approx, out_err, out_sum} !== ex) begin
                        n_fail++;
                        $display("FAIL stream_beat%0d got apx/err/sum=%h want %h", recv,
                                 {out_approx, out_err, out_sum}, ex);
                    end
                end
                recv++;
            end
            stall = out_valid && !out_ready;
            hs = out_sum; he = out_err; ha = out_approx;
            tick();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++;
        if (recv !== 100 || q.size() !== 0) begin
            n_fail++; $display("FAIL stream_count got recv=%0d left=%0d want 100 0", recv, q.size());
        end
        n_cmp++;
        if (txn_cnt !== 16'd100) begin n_fail++; $display("FAIL stream_txn got %0d want 100", txn_cnt); end
        n_cmp++;
        if (d4_txn !== 4'd15) begin n_fail++; $display("FAIL stream_txn_cw4 got %0d want 15", d4_txn); end
    endtask

    task automatic test_backpressure();
        logic [18:0] q[$]; logic [18:0] ex;
        int acc = 0, nin = 0, nout = 0;
        out_ready = 1'b0; in_approx = 1'b0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1; in_a = 16'(100 + acc); in_b = 16'(3 * acc);
            #1;
            if (in_ready) begin q.push_back(ref_beat(in_a, in_b, 1'b0)); acc++; end
            tick();
        end
        n_cmp++;
        if (acc !== 3 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_fill got acc=%0d rdy=%0b vld=%0b want 3 0 1", acc, in_ready, out_valid);
        end
        for (int c = 0; c < 8; c++) begin
            out_ready = 1'b1; in_valid = 1'b1; in_a = 16'(100 + acc); in_b = 16'(3 * acc);
            #1;
            if (in_ready) begin q.push_back(ref_beat(in_a, in_b, 1'b0)); acc++; nin++; end
            if (out_valid) begin
                nout++;
                ex = q.pop_front();
                n_cmp++;
                if ({out_approx, out_err, out_sum} !== ex) begin
                    n_fail++; $display("FAIL bp_beat got %h want %h", {out_approx, out_err, out_sum}, ex);
                end
            end
            tick();
        end
        n_cmp++;
        if (nin !== 8 || nout !== 8) begin
            n_fail++; $display("FAIL bp_throughput got in=%0d out=%0d want 8 8", nin, nout);
        end
        in_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid && q.size() != 0) begin
                ex = q.pop_front();
                n_cmp++;
                if ({out_approx, out_err, out_sum} !== ex) begin
                    n_fail++; $display("FAIL bp_drain got %h want %h", {out_approx, out_err, out_sum}, ex);
                end
            end
            tick();
        end
        n_cmp++;
        if (q.size() !== 0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_drain_left got left=%0d vld=%0b want 0 0", q.size(), out_valid);
        end
    endtask

    task automatic test_clr_on_handshake();
        int lat; logic [16:0] s; logic e, m;
        send_beat(16'h000F, 16'h0001, 1'b1, lat, s, e, m);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        n_cmp++;
        if (txn_cnt !== 16'd0 || err_cnt !== 16'd0 || d4_txn !== 4'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_handshake got txn=%0d err=%0d txn4=%0d vld=%0b want 0 0 0 0",
                     txn_cnt, err_cnt, d4_txn, out_valid);
        end
    endtask

    task automatic test_saturate();
        int sent = 0, recv = 0, cyc = 0;
        out_ready = 1'b1; in_a = 16'h000F; in_b = 16'h0001; in_approx = 1'b1;
        while (recv < 20 && cyc < 200) begin
            in_valid = (sent < 20);
            #1;
            if (in_valid && in_ready) sent++;
            if (out_valid) recv++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (d4_txn !== 4'd15 || d4_err !== 4'd15) begin
            n_fail++; $display("FAIL sat_cw4 got txn=%0d err=%0d want 15 15", d4_txn, d4_err);
        end
        n_cmp++;
        if (txn_cnt !== 16'd20 || err_cnt !== 16'd20) begin
            n_fail++; $display("FAIL sat_cw16 got txn=%0d err=%0d want 20 20", txn_cnt, err_cnt);
        end
    endtask

    task automatic test_rst_inflight();
        int acc = 0, seen = 0;
        out_ready = 1'b0; in_approx = 1'b0;
        for (int c = 0; c < 6 && acc < 3; c++) begin
            in_valid = 1'b1; in_a = 16'(7 + acc); in_b = 16'h0100;
            #1;
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_prefill got vld=%0b rdy=%0b want 1 0", out_valid, in_ready);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_drop got %0b want 0", out_valid); end
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) seen++;
            tick();
        end
        n_cmp++;
        if (seen !== 0 || txn_cnt !== 16'd0) begin
            n_fail++; $display("FAIL rst_no_stale got beats=%0d txn=%0d want 0 0", seen, txn_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_approx();
        test_back_to_back();
        test_backpressure();
        test_clr_on_handshake();
        test_saturate();
        test_rst_inflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
